// File: rtl/pulse_width_decoder_pkg.sv
// Shared types and constants for the pulse-width stream decoder.
package pulse_width_decoder_pkg;

  localparam int PWM_PERIOD       = 512;
  localparam int PULSE_WIDTH_BITS = $clog2(PWM_PERIOD);
  localparam int PHASE_BITS       = 8;

  typedef logic [PULSE_WIDTH_BITS-1:0] pulse_width_t;
  typedef logic [PHASE_BITS-1:0]       phase_t;

  typedef struct packed {
    pulse_width_t rise;
    pulse_width_t fall;
  } edge_t;

  // Centre at 2*phase; odd widths put the extra tick after the centre.
  function automatic edge_t calc_edges(pulse_width_t pw, phase_t phase);
    pulse_width_t c, lo, hi;
    edge_t        e;
    c      = {phase, 1'b0};
    lo     = pw >> 1;
    hi     = pw - lo;
    e.rise = c - lo;
    e.fall = c + hi;
    return e;
  endfunction

endpackage

// File: rtl/pulse_width_decoder_pwm_edge_calc.sv
// Single registered stage turning (pulse width, phase) into rise/fall ticks.
module pwm_edge_calc
  import pulse_width_decoder_pkg::*;
(
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en,
  input  pulse_width_t pulse_width,
  input  phase_t       phase,
  output edge_t        edge_q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      edge_q <= '0;
    end else if (en) begin
      edge_q <= calc_edges(pulse_width, phase);
    end
  end

endmodule

// File: rtl/pulse_width_decoder.sv
// Frame decoder: beats -> shadow edge buffer -> active edges, swapped only on UPDATE.
module pulse_width_decoder
  import pulse_width_decoder_pkg::*;
#(
  parameter int DEPTH = 249
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic                                DIN_VALID,
  input  logic [PULSE_WIDTH_BITS-1:0]         PULSE_WIDTH_IN,
  input  logic [PHASE_BITS-1:0]               PHASE_IN,
  input  logic                                UPDATE,
  output logic [DEPTH*PULSE_WIDTH_BITS-1:0]   RISE,
  output logic [DEPTH*PULSE_WIDTH_BITS-1:0]   FALL,
  output logic                                DOUT_VALID,
  output logic                                OVERRUN
);

  localparam int             IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [IDX_W-1:0] beat_idx, s0_idx, s1_idx;
  logic             s0_valid, s0_last, s1_valid, s1_last;
  pulse_width_t     s0_pw;
  phase_t           s0_phase;
  edge_t            s1_edge;
  logic             pending, overrun_pre;
  logic             frame_done, apply;

  logic [DEPTH-1:0][PULSE_WIDTH_BITS-1:0] shadow_rise, shadow_fall;
  logic [DEPTH-1:0][PULSE_WIDTH_BITS-1:0] active_rise, active_fall;

  // Input capture; the beat index travels with the data down the pipe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      beat_idx <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_idx   <= '0;
      s0_pw    <= '0;
      s0_phase <= '0;
    end else begin
      s0_valid <= DIN_VALID;
      if (DIN_VALID) begin
        s0_pw    <= PULSE_WIDTH_IN;
        s0_phase <= PHASE_IN;
        s0_idx   <= beat_idx;
        s0_last  <= (beat_idx == LAST_IDX);
        beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
      end
    end
  end

  pwm_edge_calc u_edge_calc (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .en          (s0_valid),
    .pulse_width (s0_pw),
    .phase       (s0_phase),
    .edge_q      (s1_edge)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_last  <= s0_valid && s0_last;
      s1_idx   <= s0_idx;
    end
  end

  assign frame_done = s1_valid && s1_last;
  assign apply      = UPDATE && pending;

  // A completion on the apply edge re-arms pending, so set beats clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow_rise <= '0;
      shadow_fall <= '0;
      active_rise <= '0;
      active_fall <= '0;
      pending     <= 1'b0;
      overrun_pre <= 1'b0;
      OVERRUN     <= 1'b0;
      DOUT_VALID  <= 1'b0;
    end else begin
      if (s1_valid) begin
        shadow_rise[s1_idx] <= s1_edge.rise;
        shadow_fall[s1_idx] <= s1_edge.fall;
      end
      if (apply) begin
        active_rise <= shadow_rise;
        active_fall <= shadow_fall;
      end
      DOUT_VALID  <= apply;
      pending     <= frame_done ? 1'b1 : (apply ? 1'b0 : pending);
      overrun_pre <= frame_done && pending && !UPDATE;
      OVERRUN     <= overrun_pre;
    end
  end

  assign RISE = active_rise;
  assign FALL = active_fall;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder: frames, wrap edges, apply timing, overrun, reset.
module tb_pulse_width_decoder;

  localparam int DEPTH = 249;

  logic                 CLK = 1'b0;
  logic                 RST_N = 1'b0;
  logic                 DIN_VALID = 1'b0;
  logic [8:0]           PULSE_WIDTH_IN = '0;
  logic [7:0]           PHASE_IN = '0;
  logic                 UPDATE = 1'b0;
  logic [DEPTH*9-1:0]   RISE, FALL;
  logic                 DOUT_VALID, OVERRUN;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] pw_tab [DEPTH];
  logic [7:0] ph_tab [DEPTH];

  pulse_width_decoder #(.DEPTH(DEPTH)) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .DIN_VALID      (DIN_VALID),
    .PULSE_WIDTH_IN (PULSE_WIDTH_IN),
    .PHASE_IN       (PHASE_IN),
    .UPDATE         (UPDATE),
    .RISE           (RISE),
    .FALL           (FALL),
    .DOUT_VALID     (DOUT_VALID),
    .OVERRUN        (OVERRUN)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] rise_at(int i);
    return RISE[i*9 +: 9];
  endfunction

  function automatic logic [8:0] fall_at(int i);
    return FALL[i*9 +: 9];
  endfunction

  task automatic fill_tab(input logic [8:0] pw, input logic [7:0] ph);
    for (int i = 0; i < DEPTH; i++) begin
      pw_tab[i] = pw;
      ph_tab[i] = ph;
    end
  endtask

  // Returns at the falling edge just after the last beat was sampled.
  task automatic send_frame(input bit gaps);
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      if (gaps) begin
        n = $urandom_range(0, 2);
        repeat (n) begin
          @(negedge CLK);
          DIN_VALID = 1'b0;
        end
      end
      @(negedge CLK);
      DIN_VALID      = 1'b1;
      PULSE_WIDTH_IN = pw_tab[i];
      PHASE_IN       = ph_tab[i];
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
  endtask

  task automatic pulse_update();
    @(negedge CLK);
    UPDATE = 1'b1;
    @(negedge CLK);
    UPDATE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    for (int i = 0; i < DEPTH; i += 31) begin
      vectors++;
      if (rise_at(i) !== 9'd0 || fall_at(i) !== 9'd0) begin
        miscompares++;
        $display("FAIL reset_edges idx %0d: got %0d/%0d want 0/0", i, rise_at(i), fall_at(i));
      end
    end
    UPDATE = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      UPDATE = 1'b0;
      vectors++;
      if (DOUT_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle_pulses cyc %0d: dout_valid=%b overrun=%b want 0/0", c, DOUT_VALID, OVERRUN);
      end
    end
    vectors++;
    if (rise_at(0) !== 9'd0 || fall_at(DEPTH-1) !== 9'd0) begin
      miscompares++;
      $display("FAIL reset_update_noeffect: got %0d/%0d want 0/0", rise_at(0), fall_at(DEPTH-1));
    end
  endtask

  task automatic test_uniform();
    fill_tab(9'd256, 8'd128);
    send_frame(1'b0);
    repeat (2) @(negedge CLK);
    vectors++;
    if (rise_at(5) !== 9'd0 || DOUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL uniform_pre_update: rise5=%0d dv=%b want 0/0", rise_at(5), DOUT_VALID);
    end
    pulse_update();
    vectors++;
    if (DOUT_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL uniform_dout_valid: got %b want 1", DOUT_VALID);
    end
    for (int i = 0; i < DEPTH; i++) begin
      vectors++;
      if (rise_at(i) !== 9'd128 || fall_at(i) !== 9'd384) begin
        miscompares++;
        $display("FAIL uniform_edges idx %0d: got %0d/%0d want 128/384", i, rise_at(i), fall_at(i));
      end
    end
    @(negedge CLK);
    vectors++;
    if (DOUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL uniform_dout_valid_width: got %b want 0", DOUT_VALID);
    end
  endtask

  task automatic test_wrap();
    fill_tab(9'd0, 8'd0);
    pw_tab[0] = 9'd100; ph_tab[0] = 8'd10;
    pw_tab[1] = 9'd511; ph_tab[1] = 8'd255;
    send_frame(1'b0);
    repeat (2) @(negedge CLK);
    pulse_update();
    vectors++;
    if (rise_at(0) !== 9'd482 || fall_at(0) !== 9'd70) begin
      miscompares++;
      $display("FAIL wrap_idx0: got %0d/%0d want 482/70", rise_at(0), fall_at(0));
    end
    vectors++;
    if (rise_at(1) !== 9'd255 || fall_at(1) !== 9'd254) begin
      miscompares++;
      $display("FAIL wrap_idx1: got %0d/%0d want 255/254", rise_at(1), fall_at(1));
    end
    for (int i = 2; i < DEPTH; i++) begin
      vectors++;
      if (rise_at(i) !== 9'd0 || fall_at(i) !== 9'd0) begin
        miscompares++;
        $display("FAIL wrap_zero_width idx %0d: got %0d/%0d want 0/0", i, rise_at(i), fall_at(i));
      end
    end
  endtask

  task automatic test_update_collision();
    int dv_count;
    fill_tab(9'd2, 8'd1);
    send_frame(1'b0);
    @(negedge CLK);
    UPDATE = 1'b1;
    @(negedge CLK);
    UPDATE = 1'b0;
    vectors++;
    if (DOUT_VALID !== 1'b0 || rise_at(0) !== 9'd482) begin
      miscompares++;
      $display("FAIL collision_no_apply: dv=%b rise0=%0d want 0/482", DOUT_VALID, rise_at(0));
    end
    @(negedge CLK);
    pulse_update();
    vectors++;
    if (DOUT_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL collision_late_apply_dv: got %b want 1", DOUT_VALID);
    end
    vectors++;
    if (rise_at(0) !== 9'd1 || fall_at(0) !== 9'd3 || rise_at(DEPTH-1) !== 9'd1) begin
      miscompares++;
      $display("FAIL collision_late_apply_edges: got %0d/%0d/%0d want 1/3/1", rise_at(0), fall_at(0), rise_at(DEPTH-1));
    end
    dv_count = 0;
    UPDATE = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      UPDATE = 1'b0;
      if (DOUT_VALID === 1'b1) dv_count++;
    end
    vectors++;
    if (dv_count !== 0) begin
      miscompares++;
      $display("FAIL collision_single_dv: extra pulses %0d want 0", dv_count);
    end
  endtask

  task automatic test_overrun();
    fill_tab(9'd10, 8'd50);
    send_frame(1'b0);
    fill_tab(9'd3, 8'd0);
    send_frame(1'b0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      vectors++;
      if (OVERRUN !== (c == 3)) begin
        miscompares++;
        $display("FAIL overrun_pulse E+%0d: got %b want %b", c, OVERRUN, (c == 3));
      end
    end
    pulse_update();
    vectors++;
    if (DOUT_VALID !== 1'b1 || rise_at(0) !== 9'd511 || fall_at(0) !== 9'd2
        || rise_at(DEPTH-1) !== 9'd511 || fall_at(DEPTH-1) !== 9'd2) begin
      miscompares++;
      $display("FAIL overrun_frame2: dv=%b got %0d/%0d %0d/%0d want 1 511/2 511/2",
               DOUT_VALID, rise_at(0), fall_at(0), rise_at(DEPTH-1), fall_at(DEPTH-1));
    end
  endtask

  task automatic test_back_to_back();
    fill_tab(9'd4, 8'd8);
    send_frame(1'b0);
    fill_tab(9'd6, 8'd20);
    send_frame(1'b0);
    @(negedge CLK);
    UPDATE = 1'b1;
    @(negedge CLK);
    UPDATE = 1'b0;
    vectors++;
    if (DOUT_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_apply_dv: got %b want 1", DOUT_VALID);
    end
    vectors++;
    if (rise_at(0) !== 9'd37 || fall_at(0) !== 9'd43 || rise_at(DEPTH-1) !== 9'd14 || fall_at(DEPTH-1) !== 9'd18) begin
      miscompares++;
      $display("FAIL b2b_mixed_frame: got %0d/%0d %0d/%0d want 37/43 14/18",
               rise_at(0), fall_at(0), rise_at(DEPTH-1), fall_at(DEPTH-1));
    end
    @(negedge CLK);
    vectors++;
    if (OVERRUN !== 1'b0 || DOUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_no_overrun: overrun=%b dv=%b want 0/0", OVERRUN, DOUT_VALID);
    end
    pulse_update();
    vectors++;
    if (DOUT_VALID !== 1'b1 || rise_at(DEPTH-1) !== 9'd37 || fall_at(DEPTH-1) !== 9'd43) begin
      miscompares++;
      $display("FAIL b2b_set_wins: dv=%b got %0d/%0d want 1 37/43", DOUT_VALID, rise_at(DEPTH-1), fall_at(DEPTH-1));
    end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      DIN_VALID      = 1'b1;
      PULSE_WIDTH_IN = 9'd50;
      PHASE_IN       = 8'd100;
    end
    @(negedge CLK);
    DIN_VALID = 1'b0;
    RST_N     = 1'b0;
    #1;
    vectors++;
    if (rise_at(0) !== 9'd0 || fall_at(DEPTH-1) !== 9'd0 || DOUT_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_reset_clear: got %0d/%0d dv=%b want 0/0/0", rise_at(0), fall_at(DEPTH-1), DOUT_VALID);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    fill_tab(9'd20, 8'd3);
    pw_tab[0] = 9'd7; ph_tab[0] = 8'd200;
    send_frame(1'b1);
    repeat (2) @(negedge CLK);
    pulse_update();
    vectors++;
    if (DOUT_VALID !== 1'b1 || rise_at(0) !== 9'd397 || fall_at(0) !== 9'd404) begin
      miscompares++;
      $display("FAIL midframe_idx0: dv=%b got %0d/%0d want 1 397/404", DOUT_VALID, rise_at(0), fall_at(0));
    end
    for (int i = 1; i < DEPTH; i++) begin
      vectors++;
      if (rise_at(i) !== 9'd508 || fall_at(i) !== 9'd16) begin
        miscompares++;
        $display("FAIL midframe_edges idx %0d: got %0d/%0d want 508/16", i, rise_at(i), fall_at(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_wrap();
    test_update_collision();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
